// File: rtl/regfile_writeback_queue.sv
// Write-back queue feeding the 64-bit x 32 register file: in-order FIFO, one drain per cycle,
// with optional forwarding of pending writes when WB_FORWARD_EN is defined.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instruction,
  input  logic                       in_regdst,
  input  logic                       in_regwrite,
  input  logic                       in_memtoreg,
  input  logic [DATA_W-1:0]          in_alu_data,
  input  logic [DATA_W-1:0]          in_mem_data,
  input  logic                       wb_stall,
  output logic                       regwrite,
  output logic [4:0]                 writeregister,
  output logic [DATA_W-1:0]          writedata,
  input  logic [4:0]                 rd_addr1,
  input  logic [4:0]                 rd_addr2,
  output logic                       fwd1_hit,
  output logic [DATA_W-1:0]          fwd1_data,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]     pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [4:0]        mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [4:0]        dest;
  logic [DATA_W-1:0] in_data;
  logic              push;
  logic              pop;
  logic              unused_instr_bits;

  // Handshake: a result transfers on a rising edge where in_valid & in_ready; in_ready depends
  // only on occupancy, never on a same-cycle pop. Dropped results (no write or r0) still transfer.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign dest     = in_regdst ? in_instruction[15:11] : in_instruction[20:16];
  assign in_data  = in_memtoreg ? in_mem_data : in_alu_data;
  assign push     = in_valid & in_ready & in_regwrite & (dest != 5'd0);
  assign pop      = (count_q != '0) & ~wb_stall;

  assign unused_instr_bits = ^{in_instruction[31:21], in_instruction[10:0]};

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_addr_d  = mem_addr_q[rd_ptr_q];
      out_data_d  = mem_data_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: only slots covered by count_q are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= dest;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

  assign regwrite      = out_valid_q;
  assign writeregister = out_addr_q;
  assign writedata     = out_data_q;
  assign pending_count = count_q;

`ifdef WB_FORWARD_EN
  // Output stage is the oldest candidate; FIFO slots are walked oldest to youngest so the
  // youngest match overwrites earlier ones.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [4:0] addr);
    logic [DATA_W:0]  r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (addr != 5'd0) begin
      if (out_valid_q && (out_addr_q == addr)) r = {1'b1, out_data_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem_addr_q[idx] == addr)) r = {1'b1, mem_data_q[idx]};
      end
    end
    return r;
  endfunction

  logic [DATA_W:0] fwd1_r, fwd2_r;

  always_comb begin
    fwd1_r = fwd_lookup(rd_addr1);
    fwd2_r = fwd_lookup(rd_addr2);
  end

  assign fwd1_hit  = fwd1_r[DATA_W];
  assign fwd1_data = fwd1_r[DATA_W-1:0];
  assign fwd2_hit  = fwd2_r[DATA_W];
  assign fwd2_data = fwd2_r[DATA_W-1:0];
`else
  logic unused_rd_addrs;
  assign unused_rd_addrs = ^{rd_addr1, rd_addr2};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: vector table plus hand-written multi-cycle sequences.
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instruction;
  logic              in_regdst;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_mem_data;
  logic              wb_stall;
  logic              regwrite;
  logic [4:0]        writeregister;
  logic [DATA_W-1:0] writedata;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic              fwd1_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd2_data;
  logic [2:0]        pending_count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_regdst      (in_regdst),
    .in_regwrite    (in_regwrite),
    .in_memtoreg    (in_memtoreg),
    .in_alu_data    (in_alu_data),
    .in_mem_data    (in_mem_data),
    .wb_stall       (wb_stall),
    .regwrite       (regwrite),
    .writeregister  (writeregister),
    .writedata      (writedata),
    .rd_addr1       (rd_addr1),
    .rd_addr2       (rd_addr2),
    .fwd1_hit       (fwd1_hit),
    .fwd1_data      (fwd1_data),
    .fwd2_hit       (fwd2_hit),
    .fwd2_data      (fwd2_data),
    .pending_count  (pending_count)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Vector table
  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        regdst;
    logic        regwr;
    logic        memtoreg;
    logic [63:0] alu;
    logic [63:0] mem;
    logic        stall;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic        exp_rw;
    logic [4:0]  exp_wreg;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [13];

  // Scoreboard model for the hand-written sequences
  logic [68:0] exp_q [$];
  int          m_count = 0;
  logic [4:0]  m_last_addr = '0;
  logic [63:0] m_last_data = '0;

  task automatic drive_cycle(input logic valid, input logic [4:0] addr, input logic [63:0] data,
                             input logic stall);
    logic        m_push, m_pop;
    logic [68:0] e;
    in_valid       = valid;
    in_instruction = {16'h0, addr, 11'h0};
    in_regdst      = 1'b1;
    in_regwrite    = 1'b1;
    in_memtoreg    = 1'b0;
    in_alu_data    = data;
    in_mem_data    = ~data;
    wb_stall       = stall;
    #1;
    check("seq ready", {63'h0, in_ready}, {63'h0, (m_count != DEPTH)});
    check("seq count_pre", {61'h0, pending_count}, 64'(m_count));
    m_push = valid && (m_count != DEPTH) && (addr != 5'd0);
    m_pop  = (m_count != 0) && !stall;
    if (m_pop) begin
      e = exp_q.pop_front();
      m_last_addr = e[68:64];
      m_last_data = e[63:0];
      m_count--;
    end
    if (m_push) begin
      exp_q.push_back({addr, data});
      m_count++;
    end
    @(posedge clock);
    #1;
    check("seq regwrite", {63'h0, regwrite}, {63'h0, m_pop});
    check("seq wreg", {59'h0, writeregister}, {59'h0, m_last_addr});
    check("seq wdata", writedata, m_last_data);
  endtask

  initial begin
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    in_regdst      = 1'b0;
    in_regwrite    = 1'b0;
    in_memtoreg    = 1'b0;
    in_alu_data    = '0;
    in_mem_data    = '0;
    wb_stall       = 1'b0;
    rd_addr1       = '0;
    rd_addr2       = '0;

    vecs[0]  = '{1'b1, 32'h0043_2820, 1'b1, 1'b1, 1'b0, 64'h1111, 64'h0,    1'b0, 1'b1, 3'd1, 1'b0, 5'd0, 64'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 1'b1, 3'd0, 1'b1, 5'd5, 64'h1111};
    vecs[2]  = '{1'b1, 32'h0043_2820, 1'b0, 1'b1, 1'b1, 64'hdead, 64'h2222, 1'b0, 1'b1, 3'd1, 1'b0, 5'd5, 64'h1111};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 1'b1, 3'd0, 1'b1, 5'd3, 64'h2222};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 64'h5555, 64'h0,    1'b0, 1'b1, 3'd0, 1'b0, 5'd3, 64'h2222};
    vecs[5]  = '{1'b1, 32'h0000_3800, 1'b1, 1'b0, 1'b0, 64'h7777, 64'h0,    1'b0, 1'b1, 3'd0, 1'b0, 5'd3, 64'h2222};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 1'b1, 3'd0, 1'b0, 5'd3, 64'h2222};
    vecs[7]  = '{1'b1, 32'h0000_5000, 1'b0, 1'b1, 1'b0, 64'h8888, 64'h0,    1'b0, 1'b1, 3'd0, 1'b0, 5'd3, 64'h2222};
    vecs[8]  = '{1'b1, 32'h0000_0800, 1'b1, 1'b1, 1'b0, 64'h10,   64'h0,    1'b0, 1'b1, 3'd1, 1'b0, 5'd3, 64'h2222};
    vecs[9]  = '{1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 64'h20,   64'h0,    1'b0, 1'b1, 3'd1, 1'b1, 5'd1, 64'h10};
    vecs[10] = '{1'b1, 32'h0000_1800, 1'b1, 1'b1, 1'b0, 64'h30,   64'h0,    1'b0, 1'b1, 3'd1, 1'b1, 5'd2, 64'h20};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 1'b1, 3'd0, 1'b1, 5'd3, 64'h30};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 1'b1, 3'd0, 1'b0, 5'd3, 64'h30};

    #1;
    check("rst count", {61'h0, pending_count}, 64'h0);
    check("rst regwrite", {63'h0, regwrite}, 64'h0);
    check("rst wreg", {59'h0, writeregister}, 64'h0);
    check("rst wdata", writedata, 64'h0);
    check("rst ready", {63'h0, in_ready}, 64'h1);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      in_valid       = vecs[i].valid;
      in_instruction = vecs[i].instr;
      in_regdst      = vecs[i].regdst;
      in_regwrite    = vecs[i].regwr;
      in_memtoreg    = vecs[i].memtoreg;
      in_alu_data    = vecs[i].alu;
      in_mem_data    = vecs[i].mem;
      wb_stall       = vecs[i].stall;
      #1;
      check($sformatf("v%0d ready", i), {63'h0, in_ready}, {63'h0, vecs[i].exp_ready});
      @(posedge clock);
      #1;
      check($sformatf("v%0d count", i), {61'h0, pending_count}, {61'h0, vecs[i].exp_count});
      check($sformatf("v%0d regwrite", i), {63'h0, regwrite}, {63'h0, vecs[i].exp_rw});
      check($sformatf("v%0d wreg", i), {59'h0, writeregister}, {59'h0, vecs[i].exp_wreg});
      check($sformatf("v%0d wdata", i), writedata, vecs[i].exp_wdata);
    end
    m_count     = 0;
    m_last_addr = 5'd3;
    m_last_data = 64'h30;

    // Forwarding: two pending writes to r9, youngest must win
    drive_cycle(1'b1, 5'd9, 64'hA, 1'b1);
    drive_cycle(1'b1, 5'd9, 64'hB, 1'b1);
    in_valid = 1'b0;
    rd_addr1 = 5'd9;
    rd_addr2 = 5'd0;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd1 hit", {63'h0, fwd1_hit}, 64'h1);
    check("fwd1 data", fwd1_data, 64'hB);
    check("fwd2 hit r0", {63'h0, fwd2_hit}, 64'h0);
    check("fwd2 data r0", fwd2_data, 64'h0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    check("fwd1 fifo over outstage", fwd1_data, 64'hB);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    check("fwd1 outstage hit", {63'h0, fwd1_hit}, 64'h1);
    check("fwd1 outstage data", fwd1_data, 64'hB);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    check("fwd1 none", {63'h0, fwd1_hit}, 64'h0);
    check("fwd1 none data", fwd1_data, 64'h0);
`else
    check("fwd1 tied", {63'h0, fwd1_hit}, 64'h0);
    check("fwd1 data tied", fwd1_data, 64'h0);
    check("fwd2 tied", {63'h0, fwd2_hit}, 64'h0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
`endif
    rd_addr1 = 5'd0;

    // Fill under stall, then drain while the producer keeps offering results
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 5'(4 + k), 64'(16 * (4 + k)), 1'b1);
    begin
      int k;
      logic acc;
      k = 0;
      for (int c = 0; c < 10 && k < 4; c++) begin
        acc = (m_count != DEPTH);
        drive_cycle(1'b1, 5'(8 + k), 64'(16 * (8 + k)), 1'b0);
        if (acc) k++;
      end
      check("fill loop accepted", 64'(k), 64'd4);
    end
    for (int c = 0; c < 5; c++) drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);

    // Stall mid-drain: stall pattern 0,1,0 gives regwrite 1,0,1
    drive_cycle(1'b1, 5'd12, 64'hC0, 1'b1);
    drive_cycle(1'b1, 5'd13, 64'hD0, 1'b1);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b1);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);
    drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);

    // Reset mid-stream with three entries queued
    drive_cycle(1'b1, 5'd14, 64'hE0, 1'b1);
    drive_cycle(1'b1, 5'd15, 64'hF0, 1'b1);
    drive_cycle(1'b1, 5'd16, 64'h100, 1'b1);
    in_valid = 1'b0;
    rd_addr1 = 5'd14;
    rd_addr2 = 5'd16;
    check("pre-rst count", {61'h0, pending_count}, 64'd3);
    reset_n = 1'b0;
    #1;
    check("mid rst count", {61'h0, pending_count}, 64'h0);
    check("mid rst regwrite", {63'h0, regwrite}, 64'h0);
    check("mid rst ready", {63'h0, in_ready}, 64'h1);
    check("mid rst wreg", {59'h0, writeregister}, 64'h0);
    check("mid rst wdata", writedata, 64'h0);
    check("mid rst fwd1", {63'h0, fwd1_hit}, 64'h0);
    check("mid rst fwd2", {63'h0, fwd2_hit}, 64'h0);
    exp_q.delete();
    m_count     = 0;
    m_last_addr = '0;
    m_last_data = '0;
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    for (int c = 0; c < 3; c++) drive_cycle(1'b0, 5'd0, 64'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
